// File: rtl/multi_chan_accum.sv
// Multi-channel windowed accumulator: emits one sum per WINDOW accepted samples on each channel.
// Optional macro ACC_SAT_EN: saturating accumulation with a sticky per-window overflow flag (default: wrap, out_ovf = 0).
module multi_chan_accum #(
  parameter int WIDTH     = 5,
  parameter int ACC_WIDTH = 16,
  parameter int CHANNELS  = 4,
  parameter int WINDOW    = 6,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH_W-1:0]      in_chan,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_chan,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf
);
  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [ACC_WIDTH-1:0] acc_q [CHANNELS];
  logic [ACC_WIDTH-1:0] acc_d [CHANNELS];
  logic [CNT_W-1:0]     cnt_q [CHANNELS];
  logic [CNT_W-1:0]     cnt_d [CHANNELS];
  logic                 out_valid_q, out_valid_d;
  logic [CH_W-1:0]      out_chan_q, out_chan_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;

  logic                 accept;
  logic                 chan_ok;
  logic                 last_beat;
  logic [ACC_WIDTH-1:0] sel_acc;
  logic [CNT_W-1:0]     sel_cnt;
  logic [ACC_WIDTH-1:0] next_acc;
`ifdef ACC_SAT_EN
  logic                 ovf_q [CHANNELS];
  logic                 ovf_d [CHANNELS];
  logic                 sel_ovf;
  logic                 sat_hit;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 out_ovf_q, out_ovf_d;
`endif

  assign in_ready = !clear && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Select the addressed channel; an out-of-range channel matches nothing and is dropped.
  always_comb begin
    chan_ok = 1'b0;
    sel_acc = '0;
    sel_cnt = '0;
`ifdef ACC_SAT_EN
    sel_ovf = 1'b0;
`endif
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (32'(in_chan) == c) begin
        chan_ok = 1'b1;
        sel_acc = acc_q[c];
        sel_cnt = cnt_q[c];
`ifdef ACC_SAT_EN
        sel_ovf = ovf_q[c];
`endif
      end
    end
    last_beat = (32'(sel_cnt) == 32'(WINDOW - 1));
`ifdef ACC_SAT_EN
    sum_ext  = {1'b0, sel_acc} + (ACC_WIDTH + 1)'(in_data);
    sat_hit  = sum_ext[ACC_WIDTH];
    next_acc = sat_hit ? '1 : sum_ext[ACC_WIDTH-1:0];
`else
    next_acc = sel_acc + ACC_WIDTH'(in_data);
`endif
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_chan_d  = out_chan_q;
    out_sum_d   = out_sum_q;
`ifdef ACC_SAT_EN
    ovf_d       = ovf_q;
    out_ovf_d   = out_ovf_q;
`endif
    if (clear) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        acc_d[c] = '0;
        cnt_d[c] = '0;
`ifdef ACC_SAT_EN
        ovf_d[c] = 1'b0;
`endif
      end
    end else if (accept && chan_ok) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (32'(in_chan) == c) begin
          if (last_beat) begin
            // Completing window overrides the handshake clear of out_valid, so no bubble.
            acc_d[c]    = '0;
            cnt_d[c]    = '0;
            out_valid_d = 1'b1;
            out_chan_d  = in_chan;
            out_sum_d   = next_acc;
`ifdef ACC_SAT_EN
            out_ovf_d   = sel_ovf || sat_hit;
            ovf_d[c]    = 1'b0;
`endif
          end else begin
            acc_d[c] = next_acc;
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
`ifdef ACC_SAT_EN
            ovf_d[c] = ovf_q[c] || sat_hit;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
`ifdef ACC_SAT_EN
        ovf_q[c] <= 1'b0;
`endif
      end
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_sum_q   <= '0;
`ifdef ACC_SAT_EN
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_sum_q   <= out_sum_d;
`ifdef ACC_SAT_EN
      ovf_q       <= ovf_d;
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_sum   = out_sum_q;
`ifdef ACC_SAT_EN
  assign out_ovf   = out_ovf_q;
`else
  assign out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_multi_chan_accum.sv
// Directed bench for multi_chan_accum: scoreboard of expected window results plus inline checks.
// A second instance with ACC_WIDTH = 7 exercises wrap/saturation (depends on ACC_SAT_EN).
module tb_multi_chan_accum;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, clear, out_valid, out_ready, out_ovf;
  logic [1:0]  in_chan, out_chan;
  logic [4:0]  in_data;
  logic [15:0] out_sum;

  logic        v7, rdy7, ov7, ovf7;
  logic [1:0]  c7, oc7;
  logic [4:0]  d7;
  logic [6:0]  sum7;

  typedef struct {
    logic [31:0] ch;
    logic [31:0] sum;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_chan_accum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_chan(in_chan), .in_data(in_data), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  multi_chan_accum #(.ACC_WIDTH(7)) dut7 (
    .clk(clk), .rst(rst), .in_valid(v7), .in_ready(rdy7),
    .in_chan(c7), .in_data(d7), .clear(1'b0),
    .out_valid(ov7), .out_ready(1'b1), .out_chan(oc7),
    .out_sum(sum7), .out_ovf(ovf7)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one beat and hold it until the DUT takes it; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] ch, input logic [4:0] data);
    int n;
    in_valid = 1'b1;
    in_chan  = ch;
    in_data  = data;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input int ch, input int sum);
    exp_t e;
    e.ch  = 32'(ch);
    e.sum = 32'(sum);
    sb.push_back(e);
  endtask

  // Scoreboard: every completed handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_result_chan", 32'(out_chan), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_chan", 32'(out_chan), e.ch);
        chk("sb_sum", 32'(out_sum), e.sum);
        chk("sb_ovf", 32'(out_ovf), 0);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_chan = '0; in_data = '0;
    clear = 1'b0; out_ready = 1'b1;
    v7 = 1'b0; c7 = '0; d7 = '0;

    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_chan", 32'(out_chan), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single window on ch0: 1..6 -> 21, one cycle after the last accept.
    push(0, 21);
    for (int i = 1; i <= 5; i++) send(2'd0, 5'(i));
    chk("win_not_early", 32'(out_valid), 0);
    send(2'd0, 5'd6);
    chk("win_valid", 32'(out_valid), 1);
    chk("win_chan", 32'(out_chan), 0);
    chk("win_sum", 32'(out_sum), 21);
    @(posedge clk); #1;

    // Backpressure: held result blocks input; a ch1 beat offered meanwhile must be refused.
    out_ready = 1'b0;
    push(0, 42);
    for (int i = 0; i < 6; i++) send(2'd0, 5'd7);
    in_valid = 1'b1; in_chan = 2'd1; in_data = 5'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_chan", 32'(out_chan), 0);
      chk("bp_sum", 32'(out_sum), 42);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released_valid", 32'(out_valid), 0);
    chk("bp_released_in_ready", 32'(in_ready), 1);

    // Interleaving: ch1 completes, ch2 completes on the very next accept (no bubble).
    push(1, 186);
    push(2, 12);
    for (int i = 0; i < 6; i++) begin
      send(2'd1, 5'h1F);
      send(2'd2, 5'h02);
    end
    chk("il_back_to_back_valid", 32'(out_valid), 1);
    chk("il_back_to_back_chan", 32'(out_chan), 2);
    chk("il_back_to_back_sum", 32'(out_sum), 12);
    @(posedge clk); #1;

    // Reset mid-window on ch3: partial window discarded, held result zeroed.
    for (int i = 0; i < 3; i++) send(2'd3, 5'd5);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_chan", 32'(out_chan), 0);
    chk("mid_rst_sum", 32'(out_sum), 0);
    chk("mid_rst_ovf", 32'(out_ovf), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push(3, 6);
    for (int i = 0; i < 6; i++) send(2'd3, 5'd1);
    chk("post_rst_sum", 32'(out_sum), 6);
    @(posedge clk); #1;

    // Clear mid-window on ch0; the beat offered during clear must not land.
    for (int i = 0; i < 4; i++) send(2'd0, 5'd2);
    clear = 1'b1; in_valid = 1'b1; in_chan = 2'd0; in_data = 5'd31;
    @(negedge clk);
    chk("clear_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    push(0, 18);
    for (int i = 0; i < 6; i++) send(2'd0, 5'd3);
    chk("post_clear_sum", 32'(out_sum), 18);
    @(posedge clk); #1;

    // Narrow accumulator: 0x1F x6 on ch0 wraps or saturates.
    chk("n7_in_ready", 32'(rdy7), 1);
    for (int i = 0; i < 6; i++) begin
      v7 = 1'b1; c7 = 2'd0; d7 = 5'h1F;
      @(posedge clk); #1;
    end
    v7 = 1'b0;
    chk("n7_valid", 32'(ov7), 1);
    chk("n7_chan", 32'(oc7), 0);
`ifdef ACC_SAT_EN
    chk("n7_sum", 32'(sum7), 127);
    chk("n7_ovf", 32'(ovf7), 1);
`else
    chk("n7_sum", 32'(sum7), 58);
    chk("n7_ovf", 32'(ovf7), 0);
`endif
    // Following window must start with a clean accumulator and overflow flag.
    for (int i = 0; i < 6; i++) begin
      v7 = 1'b1; c7 = 2'd0; d7 = 5'd1;
      @(posedge clk); #1;
    end
    v7 = 1'b0;
    chk("n7_next_sum", 32'(sum7), 6);
    chk("n7_next_ovf", 32'(ovf7), 0);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
